regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the pipelined core; replaces the single-cycle register unit.
- Provides two combinational read ports, one synchronous write port, and an optional write-to-read bypass.
- Adds a per-register busy scoreboard: decode marks the destination register pending, writeback clears it.
- Decode uses the rs1_busy and rs2_busy flags to detect RAW hazards and stall.

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus.
// Groups the read ports, the writeback port, the issue port and the
// scoreboard outputs of regfile_scoreboard.
//   master : pipeline side (drives addresses, write and issue requests)
//   slave  : register file side (returns read data and busy flags)
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    AddressRs1;
  logic [AW-1:0]    AddressRs2;
  logic [XLEN-1:0]  RFrs1;
  logic [XLEN-1:0]  RFrs2;
  logic             RFWr;
  logic [AW-1:0]    rd;
  logic [XLEN-1:0]  DataWr;
  logic             IssEn;
  logic [AW-1:0]    IssRd;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output AddressRs1, AddressRs2, RFWr, rd, DataWr, IssEn, IssRd,
    input  RFrs1, RFrs2, rs1_busy, rs2_busy, busy_vec
  );

  modport slave (
    input  AddressRs1, AddressRs2, RFWr, rd, DataWr, IssEn, IssRd,
    output RFrs1, RFrs2, rs1_busy, rs2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard.
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset (clears data and busy bits)
//   bus  : regfile_scoreboard_if.slave
//          AddressRs1/2 -> RFrs1/2      combinational reads, x0 reads 0
//          RFWr, rd, DataWr             synchronous write (optional bypass)
//          IssEn, IssRd                 mark destination pending
//          rs1_busy/rs2_busy, busy_vec  RAW hazard flags / raw scoreboard
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_scoreboard_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_ok;
  logic             iss_ok;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rs1_hz;
  logic             rs2_hz;
  logic             byp1;
  logic             byp2;

  // Address names a real, writable register (not x0, below NREGS).
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NREGS));
  endfunction

  assign wr_ok  = bus.RFWr  && in_range(bus.rd);
  assign iss_ok = bus.IssEn && in_range(bus.IssRd);

  // Set has priority over clear: a new producer supersedes the retiring one.
  always_comb begin
    busy_d = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (iss_ok && bus.IssRd == AW'(i))
        busy_d[i] = 1'b1;
      else if (wr_ok && bus.rd == AW'(i))
        busy_d[i] = 1'b0;
      else
        busy_d[i] = busy_q[i];
    end
  end

  // regs_q[0] is only ever reset, so it stays a constant zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int unsigned i = 1; i < NREGS; i++)
        if (wr_ok && bus.rd == AW'(i))
          regs_q[i] <= bus.DataWr;
    end
  end

  assign byp1 = BYPASS && wr_ok && (bus.rd == bus.AddressRs1);
  assign byp2 = BYPASS && wr_ok && (bus.rd == bus.AddressRs2);

  // Reads gated by RST so a bypassed write cannot leak out during reset.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_hz   = 1'b0;
    rs2_hz   = 1'b0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (bus.AddressRs1 == AW'(i)) begin
        rs1_data = regs_q[i];
        rs1_hz   = busy_q[i];
      end
      if (bus.AddressRs2 == AW'(i)) begin
        rs2_data = regs_q[i];
        rs2_hz   = busy_q[i];
      end
    end
    if (byp1) begin
      rs1_data = bus.DataWr;
      rs1_hz   = 1'b0;
    end
    if (byp2) begin
      rs2_data = bus.DataWr;
      rs2_hz   = 1'b0;
    end
    if (RST) begin
      rs1_data = '0;
      rs2_data = '0;
      rs1_hz   = 1'b0;
      rs2_hz   = 1'b0;
    end
  end

  assign bus.RFrs1    = rs1_data;
  assign bus.RFrs2    = rs2_data;
  assign bus.rs1_busy = rs1_hz;
  assign bus.rs2_busy = rs2_hz;
  assign bus.busy_vec = RST ? '0 : busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives two instances with identical stimulus:
//   dut_a : NREGS=32, BYPASS=1
//   dut_b : NREGS=16, BYPASS=0
module tb_regfile_scoreboard;

  logic CLK;
  logic RST;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .AW(5)) ifa ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(16), .AW(5)) ifb ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa)
  );
  regfile_scoreboard #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] dw;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e1a;
    logic [31:0] e2a;
    logic        b1a;
    logic        b2a;
    logic [31:0] bva;
    logic [31:0] e1b;
    logic [31:0] e2b;
    logic        b1b;
    logic        b2b;
    logic [31:0] bvb;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic wr,
                       input logic [4:0] rd, input logic [31:0] dw,
                       input logic iss, input logic [4:0] ird);
    ifa.AddressRs1 = a1; ifa.AddressRs2 = a2; ifa.RFWr = wr; ifa.rd = rd;
    ifa.DataWr = dw; ifa.IssEn = iss; ifa.IssRd = ird;
    ifb.AddressRs1 = a1; ifb.AddressRs2 = a2; ifb.RFWr = wr; ifb.rd = rd;
    ifb.DataWr = dw; ifb.IssEn = iss; ifb.IssRd = ird;
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] e1a, input logic [31:0] e2a,
                           input logic b1a, input logic b2a, input logic [31:0] bva,
                           input logic [31:0] e1b, input logic [31:0] e2b,
                           input logic b1b, input logic b2b, input logic [31:0] bvb);
    chk({tag, ".A.rs1"},   ifa.RFrs1, e1a);
    chk({tag, ".A.rs2"},   ifa.RFrs2, e2a);
    chk({tag, ".A.busy1"}, 32'(ifa.rs1_busy), 32'(b1a));
    chk({tag, ".A.busy2"}, 32'(ifa.rs2_busy), 32'(b2a));
    chk({tag, ".A.bvec"},  32'(ifa.busy_vec), bva);
    chk({tag, ".B.rs1"},   ifb.RFrs1, e1b);
    chk({tag, ".B.rs2"},   ifb.RFrs2, e2b);
    chk({tag, ".B.busy1"}, 32'(ifb.rs1_busy), 32'(b1b));
    chk({tag, ".B.busy2"}, 32'(ifb.rs2_busy), 32'(b2b));
    chk({tag, ".B.bvec"},  32'(ifb.busy_vec), bvb);
  endtask

  initial begin
    // Expected values are what is visible in the vector's own cycle,
    // i.e. state committed by earlier vectors plus same-cycle bypass.
    //          a1     a2     wr    rd     dw            iss   ird    | A: rs1          rs2           b1    b2    bvec          | B: rs1          rs2           b1    b2    bvec
    vec[0]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vec[1]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vec[2]  = '{5'd0,  5'd5,  1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vec[3]  = '{5'd5,  5'd6,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0};
    vec[4]  = '{5'd7,  5'd5,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0};
    vec[5]  = '{5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 32'h80,       32'h0,        32'h0,        1'b1, 1'b0, 32'h80};
    vec[6]  = '{5'd7,  5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h80,       32'h0,        32'h0,        1'b1, 1'b1, 32'h80};
    vec[7]  = '{5'd7,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0, 32'h0,        32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0, 32'h0};
    vec[8]  = '{5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
    vec[9]  = '{5'd9,  5'd0,  1'b1, 5'd9,  32'h1,        1'b1, 5'd9,  32'h1,        32'h0,        1'b0, 1'b0, 32'h200,      32'h0,        32'h0,        1'b1, 1'b0, 32'h200};
    vec[10] = '{5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h1,        32'h1,        1'b1, 1'b1, 32'h200,      32'h1,        32'h1,        1'b1, 1'b1, 32'h200};
    vec[11] = '{5'd20, 5'd9,  1'b1, 5'd20, 32'hCAFEF00D, 1'b1, 5'd20, 32'hCAFEF00D, 32'h1,        1'b0, 1'b1, 32'h200,      32'h0,        32'h1,        1'b0, 1'b1, 32'h200};
    vec[12] = '{5'd20, 5'd20, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, 32'h00100200, 32'h0,        32'h0,        1'b0, 1'b0, 32'h200};
    vec[13] = '{5'd9,  5'd20, 1'b1, 5'd9,  32'h2,        1'b0, 5'd0,  32'h2,        32'hCAFEF00D, 1'b0, 1'b1, 32'h00100200, 32'h1,        32'h0,        1'b1, 1'b0, 32'h200};
    vec[14] = '{5'd9,  5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h2,        32'h0,        1'b0, 1'b0, 32'h00100000, 32'h2,        32'h0,        1'b0, 1'b0, 32'h0};
    vec[15] = '{5'd3,  5'd4,  1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h33,       32'h0,        1'b0, 1'b0, 32'h00100008, 32'h0,        32'h0,        1'b1, 1'b0, 32'h8};
    vec[16] = '{5'd3,  5'd4,  1'b1, 5'd4,  32'h44,       1'b1, 5'd4,  32'h33,       32'h44,       1'b0, 1'b0, 32'h00100010, 32'h33,       32'h0,        1'b0, 1'b1, 32'h10};
    vec[17] = '{5'd3,  5'd4,  1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,       32'h44,       1'b0, 1'b1, 32'h00100010, 32'h33,       32'h44,       1'b0, 1'b1, 32'h10};

    // Power-on reset with a write/issue presented: must be discarded and
    // must not be bypassed to the read port.
    RST = 1'b1;
    drive(5'd6, 5'd0, 1'b1, 5'd6, 32'hFFFFFFFF, 1'b1, 5'd6);
    @(negedge CLK);
    #1;
    check_all("rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    RST = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      drive(vec[i].a1, vec[i].a2, vec[i].wr, vec[i].rd, vec[i].dw, vec[i].iss, vec[i].ird);
      #1;
      check_all($sformatf("v%0d", i), vec[i].e1a, vec[i].e2a, vec[i].b1a, vec[i].b2a, vec[i].bva,
                vec[i].e1b, vec[i].e2b, vec[i].b1b, vec[i].b2b, vec[i].bvb);
    end

    // Reset mid-operation: x3/x4 busy and holding data, 3 ns pulse between edges.
    @(negedge CLK);
    drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    check_all("pre_rst", 32'h33, 32'h44, 1'b1, 1'b1, 32'h00100018,
              32'h33, 32'h44, 1'b1, 1'b1, 32'h18);
    RST = 1'b1;
    drive(5'd3, 5'd4, 1'b1, 5'd3, 32'h55, 1'b1, 5'd5);
    #1;
    check_all("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    RST = 1'b0;
    // First edge after deassertion performs its write normally.
    drive(5'd3, 5'd4, 1'b1, 5'd3, 32'h77, 1'b0, 5'd0);
    @(negedge CLK);
    drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    check_all("post_rst", 32'h77, 32'h0, 1'b0, 1'b0, 32'h0, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    drive(5'd20, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    check_all("post_rst2", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
